down_timer: RTL and testbench

Synchronous, loadable down-counter timer: the counting-down companion to the team's 4-bit ripple up-counter. It counts a programmed value N down to zero, one step per clock, and signals expiry with a one-cycle `done` pulse. It supports hold, abort and auto-reload (periodic) modes. It sits beside the up-counter in the timing lab designs and provides delays and periodic ticks to other blocks.

---
 rtl/down_timer.sv | 92 +++++++++
 tb/tb_down_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counter timer: counts a programmed value down to zero and
// pulses done on expiry, with hold, abort and periodic auto-reload modes.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] start_val;

  // A load in the same cycle as start supplies the start value directly.
  assign start_val = load ? load_val : rld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rld   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // count is deliberately frozen so software can see where it stopped.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        if (load) begin
          rld <= load_val;
        end
        case (state)
          IDLE, DONE: begin
            if (start) begin
              if (start_val != '0) begin
                count <= start_val;
                state <= RUN;
                busy  <= 1'b1;
              end else begin
                count <= '0;
                done  <= 1'b1;
                state <= DONE;
                busy  <= 1'b0;
              end
            end else if (load) begin
              count <= load_val;
            end
          end
          RUN: begin
            if (!hold) begin
              if (count > WIDTH'(1)) begin
                count <= count - WIDTH'(1);
              end else begin
                // Reload uses the reload register as it stood before this edge.
                done <= 1'b1;
                if (auto_reload && (rld != '0)) begin
                  count <= rld;
                end else begin
                  count <= '0;
                  state <= DONE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios followed by random
// control traffic, all compared against a behavioural model every cycle.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       hold;
  logic       abort;
  logic       auto_reload;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a running flag, the remaining count and the reload value.
  int m_run  = 0;
  int m_cnt  = 0;
  int m_rld  = 0;
  int m_done = 0;

  down_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .hold        (hold),
    .abort       (abort),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run  = 0;
    m_cnt  = 0;
    m_rld  = 0;
    m_done = 0;
  endfunction

  function automatic void model_edge();
    int old_rld;
    int sv;
    m_done = 0;
    if (abort) begin
      m_run = 0;
    end else begin
      old_rld = m_rld;
      if (load) m_rld = int'(load_val);
      if (m_run == 0) begin
        if (start) begin
          sv = load ? int'(load_val) : old_rld;
          if (sv != 0) begin
            m_cnt = sv;
            m_run = 1;
          end else begin
            m_cnt  = 0;
            m_done = 1;
          end
        end else if (load) begin
          m_cnt = int'(load_val);
        end
      end else if (!hold) begin
        if (m_cnt > 1) begin
          m_cnt = m_cnt - 1;
        end else begin
          m_done = 1;
          if (auto_reload && old_rld != 0) begin
            m_cnt = old_rld;
          end else begin
            m_cnt = 0;
            m_run = 0;
          end
        end
      end
    end
  endfunction

  task automatic step(input logic a, input logic l, input logic [3:0] lv,
                      input logic s, input logic h, input logic ar);
    abort       = a;
    load        = l;
    load_val    = lv;
    start       = s;
    hold        = h;
    auto_reload = ar;
    model_edge();
    @(posedge clk);
    #1;
    $display("t=%0t ab=%0b ld=%0b lv=%0d st=%0b ho=%0b ar=%0b -> count=%0d busy=%0b done=%0b",
             $time, a, l, lv, s, h, ar, count, busy, done);
    check("count", 32'(count), 32'(m_cnt));
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0; load_val = 4'd0; start = 1'b0;
    hold = 1'b0; abort = 1'b0; auto_reload = 1'b0;
    model_reset();
    #12;
    check("reset_count", 32'(count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-run at count=5.
    step(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_step();
    check("pre_reset_count", 32'(count), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_count", 32'(count), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;

    // Load+start with 4: 4,3,2,1,0 and a single done pulse.
    step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    check("basic_first", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle_step();
    check("basic_done", 32'(done), 32'd1);
    check("basic_busy_fall", 32'(busy), 32'd0);
    idle_step();
    check("basic_done_single", 32'(done), 32'd0);

    // Hold for three cycles at count=4.
    step(1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    idle_step();
    idle_step();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      check("hold_count", 32'(count), 32'd4);
      check("hold_no_done", 32'(done), 32'd0);
    end
    for (int i = 0; i < 4; i++) idle_step();
    check("hold_late_done", 32'(done), 32'd1);

    // Abort at count=3 freezes the count with no done.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_step();
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("abort_count", 32'(count), 32'd3);
    check("abort_busy", 32'(busy), 32'd0);
    idle_step();
    check("abort_no_done", 32'(done), 32'd0);

    // Auto-reload with 3, then drop auto_reload.
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle_step();

    // Zero-length start.
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    idle_step();

    // Full-scale 15 down to 0 with no wrap.
    step(1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) idle_step();
    check("nowrap_count", 32'(count), 32'd0);

    // N=1 auto-reload keeps done high.
    step(1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("n1_done_high", 32'(done), 32'd1);
    end
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Load during RUN changes only the next reload period.
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    check("runload_count", 32'(count), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Priority: abort beats load and start.
    step(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    check("prio_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("prio_rld_kept", 32'(count), 32'd2);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    check("prio_loadstart", 32'(count), 32'd7);

    // Random control traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
